// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES slices, one slice per register stage.
// Optional signed-overflow output is enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SW = WIDTH / STAGES;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] move;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] up_c;
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [WIDTH-1:0]  s_d  [STAGES];
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  up_a [STAGES];
    logic [WIDTH-1:0]  up_b [STAGES];
    logic [WIDTH-1:0]  up_s [STAGES];
    logic [SW:0]       slice [STAGES];
    logic              chain;

    // Stage 0 is fed from the ports, every later stage from its predecessor.
    always_comb begin
        up_v[0] = in_valid;
        up_c[0] = cin;
        up_a[0] = a;
        up_b[0] = b;
        up_s[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            up_v[k] = v_q[k-1];
            up_c[k] = c_q[k-1];
            up_a[k] = a_q[k-1];
            up_b[k] = b_q[k-1];
            up_s[k] = s_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            slice[k] = {1'b0, up_a[k][k*SW +: SW]} + {1'b0, up_b[k][k*SW +: SW]}
                     + {{SW{1'b0}}, up_c[k]};
            s_d[k]   = up_s[k];
            s_d[k][k*SW +: SW] = slice[k][SW-1:0];
            c_d[k]   = slice[k][SW];
        end
    end

    // A stage may take new data if it is empty or anything downstream can drain.
    always_comb begin
        chain = out_ready;
        move  = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            chain   = chain | ~v_q[k];
            move[k] = chain;
        end
    end

    assign in_ready = move[0];
    assign load     = move & up_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (move[k]) begin
                    v_q[k] <= up_v[k];
                end
                if (load[k]) begin
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                    a_q[k] <= up_a[k];
                    b_q[k] <= up_b[k];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

    // Operand copies in the last stage have no consumer.
    logic unused_last;
    assign unused_last = ^{a_q[STAGES-1], b_q[STAGES-1]};

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
    assign ovf_d = slice[STAGES-1][SW-1] ^ up_a[STAGES-1][WIDTH-1] ^ up_b[STAGES-1][WIDTH-1]
                 ^ slice[STAGES-1][SW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (load[STAGES-1]) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: queue-based reference model checked every cycle, plus directed vectors
// with literal expectations on a 16-bit/4-stage instance and an 8-bit/1-stage instance.
module tb_pipe_adder;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic         s_in_valid;
    logic         s_in_ready;
    logic [7:0]   s_a;
    logic [7:0]   s_b;
    logic         s_cin;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [7:0]   s_sum;
    logic         s_cout;
    logic         s_ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q[$];
    exp_t outs[$];
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    pipe_adder #(.WIDTH(8), .STAGES(1)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .a         (s_a),
        .b         (s_b),
        .cin       (s_cin),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .sum       (s_sum),
        .cout      (s_cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (s_ovf)
`endif
    );

`ifndef PIPE_ADDER_OVF_EN
    assign ovf   = 1'b0;
    assign s_ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) check("drain_timeout", q.size(), 0);
    endtask

    // Reference model: an in-flight queue. The oldest entry is presentable once it has
    // seen S-1 edges after its accepting edge; the pipe is full when it holds S entries.
    always @(negedge rst_n) begin
        q.delete();
        prev_hold = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_sum", sum, 0);
            check("rst_cout", cout, 0);
            prev_hold = 1'b0;
        end else begin
            check("in_ready", in_ready, (q.size() < S) || out_ready);
            check("out_valid", out_valid, q.size() > 0 && (cyc - q[0].acc >= int'(S) - 1));
            if (out_valid && q.size() > 0) begin
                check("sum", sum, q[0].s);
                check("cout", cout, q[0].c);
`ifdef PIPE_ADDER_OVF_EN
                check("ovf", ovf, q[0].o);
`endif
            end
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_sum", sum, prev_sum);
                check("hold_cout", cout, prev_cout);
            end
            prev_hold = out_valid && !out_ready;
            prev_sum  = sum;
            prev_cout = cout;
            if (out_valid && out_ready && q.size() > 0) begin
                outs.push_back('{s: sum, c: cout, o: ovf, acc: cyc});
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                logic [W:0] full;
                full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                q.push_back('{s: full[W-1:0], c: full[W],
                              o: (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]), acc: cyc + 1});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1);
    end

    logic [W-1:0] va  [6] = '{16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0FFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] vb  [6] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'h8000};
    logic         vc  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] vs  [6] = '{16'h0000, 16'hFFFF, 16'h0100, 16'h1000, 16'h8000, 16'h0000};
    logic         vco [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         vov [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int acc_cnt;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_out_ready = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_small_out_valid", s_out_valid, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Full carry ripple and exact latency.
        in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
        step();
        in_valid = 1'b0;
        check("lat_edge0", out_valid, 0);
        step();
        check("lat_edge1", out_valid, 0);
        step();
        check("lat_edge2", out_valid, 0);
        step();
        check("lat_edge3_valid", out_valid, 1);
        check("lat_edge3_sum", sum, 16'h0000);
        check("lat_edge3_cout", cout, 1);
        drain(20);

        // Directed vectors, back to back.
        outs.delete();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i];
            step();
        end
        in_valid = 1'b0;
        drain(20);
        check("vec_count", outs.size(), 6);
        for (int i = 0; i < 6 && i < outs.size(); i++) begin
            check($sformatf("vec%0d_sum", i), outs[i].s, vs[i]);
            check($sformatf("vec%0d_cout", i), outs[i].c, vco[i]);
`ifdef PIPE_ADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i), outs[i].o, vov[i]);
`endif
        end

        // Streaming at full rate.
        outs.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = 16'(i * 32'h1111); b = 16'h0F0F; cin = i[0];
            #1;
            check("stream_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        drain(20);
        check("stream_count", outs.size(), 8);
        if (outs.size() == 8) begin
            check("stream0_sum", outs[0].s, 16'h0F0F);
            check("stream1_sum", outs[1].s, 16'h2021);
            check("stream7_sum", outs[7].s, 16'h8687);
            check("stream_gapless", outs[7].acc - outs[0].acc, 7);
        end

        // Backpressure with bubbles entering a stalled pipe.
        outs.delete();
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 4) ? !i[0] : 1'b1;
            a = 16'(32'h0100 * i + 7); b = 16'h0033; cin = 1'b0;
            #1;
            if (in_valid && in_ready) acc_cnt++;
            step();
        end
        check("bp_accepted", acc_cnt, 4);
        check("bp_in_ready", in_ready, 0);
        for (int r = 0; r < 12; r++) begin
            out_ready = (r % 4 != 1);
            a = 16'(32'h0200 * r + 3);
            #1;
            if (in_valid && in_ready) acc_cnt++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain(30);
        check("bp_no_loss", outs.size(), acc_cnt);

        // Reset with operations in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'(32'h1234 + i); b = 16'h1111; cin = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_sum", sum, 16'h2346);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_valid", out_valid, 0);
        check("mid_reset_sum", sum, 0);
        check("mid_reset_cout", cout, 0);
        check("mid_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (8) step();
        check("post_reset_valid", out_valid, 0);
        check("post_reset_in_ready", in_ready, 1);

        // Single-stage 8-bit instance: registered adder at full rate.
        s_in_valid = 1'b1; s_a = 8'hFF; s_b = 8'h00; s_cin = 1'b1;
        #1;
        check("small_in_ready", s_in_ready, 1);
        step();
        check("small0_valid", s_out_valid, 1);
        check("small0_sum", s_sum, 8'h00);
        check("small0_cout", s_cout, 1);
        s_a = 8'h12; s_b = 8'h34; s_cin = 1'b0;
        step();
        check("small1_valid", s_out_valid, 1);
        check("small1_sum", s_sum, 8'h46);
        check("small1_cout", s_cout, 0);
        s_a = 8'h80; s_b = 8'h80; s_cin = 1'b0;
        step();
        check("small2_sum", s_sum, 8'h00);
        check("small2_cout", s_cout, 1);
`ifdef PIPE_ADDER_OVF_EN
        check("small2_ovf", s_ovf, 1);
`endif
        s_in_valid = 1'b0;
        step();
        check("small_idle_valid", s_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
